filter_readout_scheduler: RTL and testbench
===========================================

# filter_readout_scheduler

Acquisition-window controller and output arbiter for the filter bank: on a start pulse it measures, over a fixed window, the signed peak value and peak position of every enabled filter channel. It then drains the results one channel at a time onto a single shared valid/ready result port. It sits beside the filter top level, taking the v1..v21 filter outputs in parallel and feeding a single downstream readout path.

## Interface
Parameters:
- NUM_CH, default 21: number of filter channels.
- WINDOW_LEN, default 256: acquisition window length in clk cycles, at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; the reset polarity and synchronicity are fixed.
- start  in  1  single-cycle request to begin a window.
- ch_enable  in  NUM_CH  channel mask, sampled only when start is accepted.
- ch_data  in  NUM_CH x SIZE_FILTER_DATA  packed filter outputs, two's complement, channel 0 in the LSBs.
- out_ready  in  1  downstream accepts the result.
- out_valid  out  1  a result is presented.
- out_channel  out  $clog2(NUM_CH)  channel index of the result.
- out_peak  out  SIZE_FILTER_DATA  signed maximum over the window.
- out_peak_pos  out  $clog2(WINDOW_LEN)  sample index of the maximum within the window.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse after the last result is accepted.
- overrun  out  1  sticky: a start arrived while busy.

## Operation
The state machine has four states: IDLE, ACQUIRE, DRAIN and DONE. Reset forces IDLE and sets every output to 0.
- IDLE:
  - start=1 latches ch_enable into the pending mask, clears all trackers and the sample counter, clears overrun, and moves to ACQUIRE.
  - start=0 stays in IDLE.
- ACQUIRE:
  - Each cycle every tracker samples its ch_data slice, and the counter increments from 0 to WINDOW_LEN-1.
  - The tracker updates on strictly greater (signed), so ties keep the earliest index.
  - Tracker init value is the most negative value, position 0.
  - After the sample at count WINDOW_LEN-1, go to DRAIN if the pending mask is nonzero, otherwise go to DONE.
- DRAIN:
  - A priority encoder selects the lowest-index pending channel, and the outputs present that channel's result with out_valid=1.
  - On valid&&ready, clear that pending bit. If bits remain, the next channel is presented the following cycle; otherwise go to DONE.
  - out_channel, out_peak and out_peak_pos must remain stable while out_valid=1 and out_ready=0.
- DONE: done=1 for one cycle, then return to IDLE.
- start while busy is ignored and sets overrun=1.
- Disabled channels are never presented.
- Peaks are not sampled outside ACQUIRE, so trackers hold their results through DRAIN.

## Timing
- Start accepted at edge k. ACQUIRE samples ch_data at edges k+1 .. k+WINDOW_LEN, and busy=1 from the cycle after edge k.
- First out_valid=1 in the cycle after edge k+WINDOW_LEN; there is no extra pipeline stage.
- Throughput is one result per cycle while out_ready is held 1.
- Final handshake at edge m gives done=1 in the cycle after m and busy=0 from the cycle after m+1. A new start is accepted at edge m+2.
- With an empty mask, done=1 in the cycle after edge k+WINDOW_LEN.
- Reset mid-window or mid-drain:
  - Next cycle is IDLE with all outputs 0, the pending mask cleared and overrun cleared.
  - No partial results are emitted.
- start and reset asserted together: reset wins.
- out_ready while out_valid=0 has no effect.

## Structure
- package_settings gains:
  - NUM_FILTERS=21
  - SIZE_CH_IDX=5
  - SIZE_WINDOW_CNT
  - the typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_DRAIN, S_DONE} readout_state_t
- The natural sub-module is filter_peak_tracker: one per channel via generate, holding a signed max and position register with clear and enable inputs.
- The top module holds the FSM, window counter, pending mask, priority encoder and output mux.

## Test plan
- **Single channel:** NUM_CH=21, WINDOW_LEN=8, ch_enable=1<<3, ch_3 sequence 5,-2,9,9,1,0,-7,3 and out_ready=1 -> one result {channel 3, peak 9, pos 2}, then done pulse, then busy=0.
- **Backpressure:**
  - Stimulus: ch_enable has bits 0, 7 and 20 set; out_ready=0 for 4 cycles, then 1.
  - Response: channel 0 is held stable for 4 cycles, then channels 0, 7 and 20 follow on consecutive cycles.
- **All-negative input:** ch_enable bit 1 set, ch_1 constant -100 -> peak -100, pos 0.
- **Empty mask:** ch_enable=0 -> out_valid never asserted; done=1 exactly WINDOW_LEN+1 cycles after the start edge.
- **Overrun and reset:**
  - A start issued mid-ACQUIRE leaves the window unchanged and sets overrun=1.
  - Reset asserted during DRAIN gives out_valid=0, busy=0 and overrun=0 next cycle.
  - A fresh start after that produces the full result set.

Source files
------------

// File: rtl/filter_readout_scheduler_pkg.sv
// Shared settings for the filter bank readout path: data/index widths and the readout FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package filter_readout_scheduler_pkg;

    localparam int SIZE_FILTER_DATA   = 16;
    localparam int NUM_FILTERS        = 21;
    localparam int SIZE_CH_IDX        = 5;
    localparam int DEFAULT_WINDOW_LEN = 256;
    localparam int SIZE_WINDOW_CNT    = $clog2(DEFAULT_WINDOW_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQUIRE,
        S_DRAIN,
        S_DONE
    } readout_state_t;

    // Most negative two's complement value, used as the tracker start point
    function automatic logic [SIZE_FILTER_DATA-1:0] min_sample();
        return {1'b1, {(SIZE_FILTER_DATA-1){1'b0}}};
    endfunction

endpackage

// File: rtl/filter_peak_tracker.sv
// Per-channel signed running maximum with the sample index at which it was first reached.
// Latency: peak/peak_pos reflect a sample one clock after it is presented with en=1.
// Backpressure: none; holds its value whenever en=0.
module filter_peak_tracker
    import filter_readout_scheduler_pkg::*;
#(
    parameter int DW = SIZE_FILTER_DATA,
    parameter int PW = SIZE_WINDOW_CNT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] sample,
    input  logic        [PW-1:0] pos,
    output logic signed [DW-1:0] peak,
    output logic        [PW-1:0] peak_pos
);

    // Strictly-greater update so ties keep the earliest position
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            peak     <= DW'(min_sample());
            peak_pos <= '0;
        end else if (en && (sample > peak)) begin
            peak     <= sample;
            peak_pos <= pos;
        end
    end

endmodule

// File: rtl/filter_readout_scheduler.sv
// Measures per-channel signed peak/position over a fixed window, then drains enabled results in channel order.
// Latency: first result valid the cycle after the last window sample; one result per cycle thereafter.
// Backpressure: out_valid/out_ready; a stalled result holds channel, peak and position stable.
module filter_readout_scheduler
    import filter_readout_scheduler_pkg::*;
#(
    parameter int NUM_CH     = NUM_FILTERS,
    parameter int WINDOW_LEN = DEFAULT_WINDOW_LEN
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [NUM_CH-1:0]                    ch_enable,
    input  logic [NUM_CH*SIZE_FILTER_DATA-1:0]   ch_data,
    input  logic                                 out_ready,
    output logic                                 out_valid,
    output logic [$clog2(NUM_CH)-1:0]            out_channel,
    output logic [SIZE_FILTER_DATA-1:0]          out_peak,
    output logic [$clog2(WINDOW_LEN)-1:0]        out_peak_pos,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 overrun
);

    localparam int CW = $clog2(NUM_CH);
    localparam int PW = $clog2(WINDOW_LEN);
    localparam int DW = SIZE_FILTER_DATA;
    localparam logic [PW-1:0] LAST_CNT = PW'(WINDOW_LEN - 1);

    readout_state_t     state_q;
    logic [PW-1:0]      cnt_q;
    logic [NUM_CH-1:0]  pending_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;
    logic               overrun_q;

    logic [CW-1:0]      sel_idx;
    logic [NUM_CH-1:0]  sel_onehot;
    logic [NUM_CH-1:0]  pending_after;
    logic               trk_clr;
    logic               trk_en;

    logic signed [DW-1:0] peak_arr [NUM_CH];
    logic        [PW-1:0] pos_arr  [NUM_CH];

    // Trackers restart on an accepted start and only sample during the window
    assign trk_clr = (state_q == S_IDLE) && start;
    assign trk_en  = (state_q == S_ACQUIRE);

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_trk
            filter_peak_tracker #(
                .DW (DW),
                .PW (PW)
            ) u_trk (
                .clk      (clk),
                .reset    (reset),
                .clr      (trk_clr),
                .en       (trk_en),
                .sample   (ch_data[g*DW +: DW]),
                .pos      (cnt_q),
                .peak     (peak_arr[g]),
                .peak_pos (pos_arr[g])
            );
        end
    endgenerate

    // Lowest-index pending channel wins; scanning downward leaves the lowest match last
    always_comb begin
        sel_idx    = '0;
        sel_onehot = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_idx    = CW'(i);
                sel_onehot = '0;
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign pending_after = pending_q & ~sel_onehot;

    // Readout FSM: window counting, pending-mask drain and sticky overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pending_q <= ch_enable;
                        cnt_q     <= '0;
                        overrun_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_ACQUIRE;
                    end
                end
                S_ACQUIRE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        cnt_q <= '0;
                        if (|pending_q) begin
                            valid_q <= 1'b1;
                            state_q <= S_DRAIN;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (valid_q && out_ready) begin
                        pending_q <= pending_after;
                        if (pending_after == '0) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Result fields come from held tracker registers and are zero whenever nothing is presented
    assign out_valid    = valid_q;
    assign out_channel  = valid_q ? sel_idx           : '0;
    assign out_peak     = valid_q ? peak_arr[sel_idx] : '0;
    assign out_peak_pos = valid_q ? pos_arr[sel_idx]  : '0;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_filter_readout_scheduler.sv
module tb_filter_readout_scheduler;
    import filter_readout_scheduler_pkg::*;

    localparam int NCH = 21;
    localparam int WL  = 8;
    localparam int DW  = SIZE_FILTER_DATA;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 out_ready = 1'b0;
    logic [NCH-1:0]       ch_enable = '0;
    logic [NCH*DW-1:0]    ch_data = '0;
    logic                 out_valid;
    logic [4:0]           out_channel;
    logic signed [DW-1:0] out_peak;
    logic [2:0]           out_peak_pos;
    logic                 busy;
    logic                 done;
    logic                 overrun;

    typedef struct {
        int ch;
        int peak;
        int pos;
    } exp_t;

    exp_t                 sb[$];
    logic signed [DW-1:0] samp [NCH][WL];
    int                   compared = 0;
    int                   mismatched = 0;

    filter_readout_scheduler #(
        .NUM_CH     (NCH),
        .WINDOW_LEN (WL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ch_enable    (ch_enable),
        .ch_data      (ch_data),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_channel  (out_channel),
        .out_peak     (out_peak),
        .out_peak_pos (out_peak_pos),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted result is popped and compared
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            compared++;
            assert (sb.size() > 0) else begin
                mismatched++;
                $error("FAIL unexpected_result: observed channel %0d expected no result", out_channel);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("res_channel", out_channel, e.ch);
                check("res_peak", out_peak, e.peak);
                check("res_pos", out_peak_pos, e.pos);
            end
        end
    end

    task automatic fill_random();
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < WL; i++)
                samp[c][i] = DW'($urandom);
    endtask

    task automatic push_expected(input logic [NCH-1:0] mask);
        int pk;
        int ps;
        for (int c = 0; c < NCH; c++) begin
            if (mask[c]) begin
                pk = -(1 << (DW - 1));
                ps = 0;
                for (int i = 0; i < WL; i++) begin
                    if (int'(samp[c][i]) > pk) begin
                        pk = int'(samp[c][i]);
                        ps = i;
                    end
                end
                sb.push_back('{c, pk, ps});
            end
        end
    endtask

    // Start a window and feed WL samples; returns in the cycle of the last sample
    task automatic run_window(input logic [NCH-1:0] mask, input int mid_start);
        @(negedge clk);
        start     = 1'b1;
        ch_enable = mask;
        push_expected(mask);
        for (int i = 0; i < WL; i++) begin
            @(negedge clk);
            start = (i == mid_start);
            for (int c = 0; c < NCH; c++)
                ch_data[c*DW +: DW] = samp[c][i];
            if (i == 0) check("busy_after_start", busy, 1);
            if (i == WL - 1) check("no_early_valid", out_valid, 0);
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        int seq [WL];

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_channel", out_channel, 0);
        check("rst_peak", out_peak, 0);
        check("rst_pos", out_peak_pos, 0);
        reset = 1'b0;

        // Single channel, fixed sequence with a tie at the maximum
        out_ready = 1'b1;
        fill_random();
        seq = '{5, -2, 9, 9, 1, 0, -7, 3};
        for (int i = 0; i < WL; i++) samp[3][i] = DW'(seq[i]);
        run_window(NCH'(1) << 3, -1);
        @(negedge clk);
        check("single_first_valid", out_valid, 1);
        check("single_channel", out_channel, 3);
        check("single_peak", out_peak, 9);
        check("single_pos", out_peak_pos, 2);
        @(negedge clk);
        check("single_done", done, 1);
        check("single_valid_off", out_valid, 0);
        @(negedge clk);
        check("single_busy_off", busy, 0);
        check("single_done_off", done, 0);
        check("single_sb_empty", sb.size(), 0);

        // Backpressure: channel 0 held 4 cycles, then 0, 7, 20 back to back
        out_ready = 1'b0;
        fill_random();
        run_window((NCH'(1) << 0) | (NCH'(1) << 7) | (NCH'(1) << 20), -1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_channel", out_channel, 0);
            check("bp_hold_peak", out_peak, sb[0].peak);
            check("bp_hold_pos", out_peak_pos, sb[0].pos);
        end
        @(negedge clk);
        out_ready = 1'b1;
        check("bp_seq0", out_channel, 0);
        @(negedge clk);
        check("bp_seq1_valid", out_valid, 1);
        check("bp_seq1", out_channel, 7);
        @(negedge clk);
        check("bp_seq2_valid", out_valid, 1);
        check("bp_seq2", out_channel, 20);
        @(negedge clk);
        check("bp_done", done, 1);
        check("bp_sb_empty", sb.size(), 0);

        // All-negative constant input
        fill_random();
        for (int i = 0; i < WL; i++) samp[1][i] = -16'sd100;
        run_window(NCH'(1) << 1, -1);
        @(negedge clk);
        check("neg_peak", out_peak, -100);
        check("neg_pos", out_peak_pos, 0);
        wait_done("neg");

        // Empty mask: done exactly WL+1 cycles after the start edge
        fill_random();
        run_window('0, -1);
        check("empty_done_early", done, 0);
        @(negedge clk);
        check("empty_done", done, 1);
        check("empty_valid", out_valid, 0);
        @(negedge clk);

        // Overrun: start mid-window is ignored but flagged
        fill_random();
        run_window(NCH'(1) << 2, 3);
        @(negedge clk);
        check("ovr_valid", out_valid, 1);
        check("ovr_flag", overrun, 1);
        wait_done("ovr");

        // Reset during drain discards results and clears overrun
        out_ready = 1'b0;
        fill_random();
        run_window((NCH'(1) << 2) | (NCH'(1) << 5), 2);
        @(negedge clk);
        check("rd_valid_before", out_valid, 1);
        check("rd_overrun_before", overrun, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rd_valid", out_valid, 0);
        check("rd_busy", busy, 0);
        check("rd_overrun", overrun, 0);
        check("rd_done", done, 0);
        sb.delete();

        // Fresh start after reset yields the full result set
        out_ready = 1'b1;
        fill_random();
        run_window((NCH'(1) << 2) | (NCH'(1) << 5), -1);
        wait_done("fresh");
        check("fresh_overrun", overrun, 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
